// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_CPU,
        BUSY_ACC
    } state_t;

    typedef enum logic {
        CPU,
        ACC
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie, the side not granted last wins.
import dmem_arb_pkg::*;

module arb_rr2 (
    input  logic   req_cpu,
    input  logic   req_acc,
    input  owner_t last_grant,
    output owner_t winner
);

    always_comb begin
        winner = CPU;
        if (req_cpu && req_acc) begin
            winner = (last_grant == CPU) ? ACC : CPU;
        end else if (req_acc) begin
            winner = ACC;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and an accelerator,
// one access outstanding at a time, fixed read latency MEM_LAT.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             acc_valid,
    input  logic             acc_we,
    input  logic [WIDTH-1:0] acc_addr,
    input  logic [WIDTH-1:0] acc_wdata,
    output logic             acc_ready,
    output logic             acc_rvalid,
    output logic [WIDTH-1:0] acc_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_range
        $error("dmem_arbiter: MEM_LAT out of range");
    end

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state;
    owner_t     last_grant;
    owner_t     winner;
    logic [2:0] cnt;
    logic       cpu_done;
    logic       lat_we;
    logic       req_cpu;
    logic       req_acc;
    logic       grant;

    // cpu_done masks the request so the finishing instruction is not re-issued
    assign req_cpu   = cpu_req && !cpu_done;
    assign req_acc   = acc_valid;
    assign grant     = (state == IDLE) && (req_cpu || req_acc);
    assign acc_ready = (state == IDLE) && req_acc && (winner == ACC);
    assign cpu_stall = cpu_req && !cpu_done;

    arb_rr2 u_arb (
        .req_cpu    (req_cpu),
        .req_acc    (req_acc),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_we     <= 1'b0;
            cpu_done   <= 1'b0;
            acc_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            acc_rdata  <= '0;
            last_grant <= ACC;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            cpu_done   <= 1'b0;
            acc_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= (winner == CPU) ? BUSY_CPU : BUSY_ACC;
                        cnt        <= LAT;
                        mem_en     <= 1'b1;
                        last_grant <= winner;
                        if (winner == CPU) begin
                            lat_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            lat_we    <= acc_we;
                            mem_we    <= acc_we;
                            mem_addr  <= acc_addr;
                            mem_wdata <= acc_wdata;
                        end
                    end
                end
                BUSY_CPU, BUSY_ACC: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        if (state == BUSY_CPU) begin
                            cpu_done <= 1'b1;
                            if (!lat_we) cpu_rdata <= mem_rdata;
                        end else begin
                            acc_rvalid <= 1'b1;
                            if (!lat_we) acc_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
